// File: rtl/fetch_stage.sv
// Instruction fetch: holds the PC, drives imem_addr and registers each word into IF/ID one cycle later.
// Stall freezes everything; a branch redirect bubbles IF/ID and drops any pending immediate tag.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [2:0]  IMM_OPCODE = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instruction,
    output logic [15:0] if_id_pc_next,
    output logic        if_id_valid,
    output logic        if_id_imm,
    output logic [15:0] fetch_count
);

    typedef enum logic {RUN = 1'b0, IMM = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcn_q, pcn_d;
    logic        valid_q, valid_d;
    logic        imm_q, imm_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pc_inc;

    assign pc_inc = pc_q + 16'd1;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        instr_d = instr_q;
        pcn_d   = pcn_q;
        valid_d = valid_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;
        if (branch_taken) begin
            pc_d    = branch_target;
            instr_d = 16'h0000;
            pcn_d   = 16'h0000;
            valid_d = 1'b0;
            imm_d   = 1'b0;
            state_d = RUN;
        end else if (!stall) begin
            pc_d    = pc_inc;
            instr_d = imem_data;
            pcn_d   = pc_inc;
            valid_d = 1'b1;
            imm_d   = (state_q == IMM);
            if (cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
            // The immediate word itself is never decoded as an opcode.
            if (state_q == IMM)
                state_d = RUN;
            else if (imem_data[15:13] == IMM_OPCODE)
                state_d = IMM;
            else
                state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            instr_q <= 16'h0000;
            pcn_q   <= 16'h0000;
            valid_q <= 1'b0;
            imm_q   <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            instr_q <= instr_d;
            pcn_q   <= pcn_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr         = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_next     = pcn_q;
    assign if_id_valid       = valid_q;
    assign if_id_imm         = imm_q;
    assign fetch_count       = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, randomized run against a reference model, wrap/saturation.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    logic        rst, stall, branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr, imem_data, if_id_instruction, if_id_pc_next, fetch_count;
    logic        if_id_valid, if_id_imm;

    logic        rst2;
    logic [15:0] imem_addr2, imem_data2, instr2, pcn2, cnt2;
    logic        valid2, imm2;

    assign imem_data  = mem[imem_addr];
    assign imem_data2 = mem[imem_addr2];

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instruction(if_id_instruction), .if_id_pc_next(if_id_pc_next),
        .if_id_valid(if_id_valid), .if_id_imm(if_id_imm), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst(rst2), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(16'h0000), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .if_id_instruction(instr2), .if_id_pc_next(pcn2),
        .if_id_valid(valid2), .if_id_imm(imm2), .fetch_count(cnt2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcn;
        logic        valid;
        logic        imm;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [15:0] addr, input logic [15:0] instr,
                             input logic [15:0] pcn, input logic valid, input logic imm,
                             input logic [15:0] cnt);
        checks++;
        if (imem_addr !== addr || if_id_instruction !== instr || if_id_pc_next !== pcn ||
            if_id_valid !== valid || if_id_imm !== imm || fetch_count !== cnt) begin
            errors++;
            $display("FAIL %s: got addr=%h instr=%h pcn=%h v=%b imm=%b cnt=%h, want addr=%h instr=%h pcn=%h v=%b imm=%b cnt=%h",
                     name, imem_addr, if_id_instruction, if_id_pc_next, if_id_valid, if_id_imm,
                     fetch_count, addr, instr, pcn, valid, imm, cnt);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic addv(input logic r, input logic s, input logic b, input logic [15:0] t,
                        input logic [15:0] a, input logic [15:0] i, input logic [15:0] p,
                        input logic v, input logic m, input logic [15:0] c);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t;
        x.addr = a; x.instr = i; x.pcn = p; x.valid = v; x.imm = m; x.cnt = c;
        vecs.push_back(x);
    endtask

    // Reference model state: architectural view only.
    logic [15:0] m_pc, m_instr, m_pcn, m_cnt;
    logic        m_valid, m_imm, m_pending_imm;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = {3'b000, a[12:0]};
        mem[0] = 16'h2000; mem[1] = 16'h4400; mem[2] = 16'h8000;
        mem[4] = 16'h6000; mem[5] = 16'h00AB;
        mem[16'h41] = 16'h6000; mem[16'h81] = 16'h6000;

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; rst2 = 1'b1;
        tick(); tick();
        check_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        //   rst stall br  tgt       addr      instr     pcn       v  imm cnt
        addv(0, 0, 0, 16'h0000, 16'h0001, 16'h2000, 16'h0001, 1, 0, 16'd1);
        addv(0, 0, 0, 16'h0000, 16'h0002, 16'h4400, 16'h0002, 1, 0, 16'd2);
        addv(0, 0, 0, 16'h0000, 16'h0003, 16'h8000, 16'h0003, 1, 0, 16'd3);
        addv(0, 0, 0, 16'h0000, 16'h0004, 16'h0003, 16'h0004, 1, 0, 16'd4);
        addv(0, 0, 0, 16'h0000, 16'h0005, 16'h6000, 16'h0005, 1, 0, 16'd5);
        addv(0, 1, 0, 16'h0000, 16'h0005, 16'h6000, 16'h0005, 1, 0, 16'd5);
        addv(0, 1, 0, 16'h0000, 16'h0005, 16'h6000, 16'h0005, 1, 0, 16'd5);
        addv(0, 1, 0, 16'h0000, 16'h0005, 16'h6000, 16'h0005, 1, 0, 16'd5);
        addv(0, 0, 0, 16'h0000, 16'h0006, 16'h00AB, 16'h0006, 1, 1, 16'd6);
        addv(0, 0, 0, 16'h0000, 16'h0007, 16'h0006, 16'h0007, 1, 0, 16'd7);
        addv(0, 1, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0, 16'd7);
        addv(0, 0, 0, 16'h0000, 16'h0041, 16'h0040, 16'h0041, 1, 0, 16'd8);
        addv(0, 0, 0, 16'h0000, 16'h0042, 16'h6000, 16'h0042, 1, 0, 16'd9);
        addv(0, 0, 1, 16'h0080, 16'h0080, 16'h0000, 16'h0000, 0, 0, 16'd9);
        addv(0, 0, 0, 16'h0000, 16'h0081, 16'h0080, 16'h0081, 1, 0, 16'd10);
        addv(0, 0, 0, 16'h0000, 16'h0082, 16'h6000, 16'h0082, 1, 0, 16'd11);
        addv(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
        addv(0, 0, 0, 16'h0000, 16'h0001, 16'h2000, 16'h0001, 1, 0, 16'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; stall = vecs[i].stall;
            branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].pcn,
                      vecs[i].valid, vecs[i].imm, vecs[i].cnt);
        end

        // Randomized run against the model, with opcode-011 words made common.
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mem[a][15:13] = 3'b011;
        end
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        tick();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pcn = 16'h0000; m_cnt = 16'h0000;
        m_valid = 1'b0; m_imm = 1'b0; m_pending_imm = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 99) < 2);
            branch_taken  = ($urandom_range(0, 99) < 10);
            stall         = ($urandom_range(0, 99) < 25);
            branch_target = 16'($urandom);
            if (rst) begin
                m_pc = 16'h0000; m_instr = 16'h0000; m_pcn = 16'h0000; m_cnt = 16'h0000;
                m_valid = 1'b0; m_imm = 1'b0; m_pending_imm = 1'b0;
            end else if (branch_taken) begin
                m_pc = branch_target; m_instr = 16'h0000; m_pcn = 16'h0000;
                m_valid = 1'b0; m_imm = 1'b0; m_pending_imm = 1'b0;
            end else if (!stall) begin
                m_instr = mem[m_pc];
                m_pcn   = 16'((32'(m_pc) + 1) % 65536);
                m_valid = 1'b1;
                m_imm   = m_pending_imm;
                m_pending_imm = !m_pending_imm && (m_instr[15:13] == 3'b011);
                m_pc    = m_pcn;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            tick();
            check_all($sformatf("rand%0d", c), m_pc, m_instr, m_pcn, m_valid, m_imm, m_cnt);
        end
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;

        // PC wrap at 16'hFFFF and fetch_count saturation.
        tick();
        rst2 = 1'b0;
        tick();
        check16("wrap_addr", imem_addr2, 16'h0000);
        check16("wrap_pcn", pcn2, 16'h0000);
        check16("wrap_instr", instr2, mem[16'hFFFF]);
        check16("wrap_cnt", cnt2, 16'h0001);
        for (int k = 0; k < 65534; k++) @(posedge clk);
        #1;
        check16("sat_reach", cnt2, 16'hFFFF);
        tick();
        check16("sat_hold", cnt2, 16'hFFFF);
        check16("sat_valid", {15'h0, valid2}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
